// File: rtl/timestamp_alarm_pkg.sv
// Shared definitions for the timestamp alarm peripheral: register map, bit indices, FSM states.
package timestamp_alarm_pkg;

    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_DEADLINE = 2'd1;
    localparam logic [1:0] ADDR_PERIOD   = 2'd2;
    localparam logic [1:0] ADDR_STATUS   = 2'd3;

    localparam int CTRL_ARM      = 0;
    localparam int CTRL_IE       = 1;
    localparam int CTRL_PERIODIC = 2;

    localparam int STATUS_FIRED  = 0;
    localparam int STATUS_MISSED = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } state_t;

endpackage

// File: rtl/timestamp_alarm_if.sv
// CPU register bus for the timestamp alarm: single-cycle write strobe, registered read return.
interface timestamp_alarm_if;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/timestamp_alarm_ts_reached.sv
// Wrap-safe "timestamp has reached deadline" compare; valid for deadlines up to 2^31-1 ahead.
module ts_reached (
    input  logic [31:0] timestamp,
    input  logic [31:0] deadline,
    output logic        reached
);
    logic [31:0] diff;

    // Modular difference: a non-negative signed result means the deadline is at or behind us.
    assign diff    = timestamp - deadline;
    assign reached = ~diff[31];
endmodule

// File: rtl/timestamp_alarm.sv
// Timer/alarm peripheral: sticky fired/missed flags and level irq when the timestamp reaches DEADLINE.
// Periodic reload is built only when TIMESTAMP_ALARM_PERIODIC_EN is defined.
module timestamp_alarm
    import timestamp_alarm_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic [31:0]        timestamp,
    timestamp_alarm_if.slave   bus,
    output logic               irq
);

    state_t      state, state_nxt;
    logic        ctrl_ie;
    logic        ctrl_periodic;
    logic [31:0] deadline;
    logic [31:0] period;
    logic        fired, missed;
    logic        reached, fire, periodic_active;
    logic        ctrl_wr, deadline_wr, status_wr;
    logic [31:0] rd_mux;

    assign ctrl_wr     = bus.wr_en && (bus.wr_addr == ADDR_CTRL);
    assign deadline_wr = bus.wr_en && (bus.wr_addr == ADDR_DEADLINE);
    assign status_wr   = bus.wr_en && (bus.wr_addr == ADDR_STATUS);

    ts_reached u_reached (
        .timestamp (timestamp),
        .deadline  (deadline),
        .reached   (reached)
    );

    // Compare uses the registers as they stood before this cycle's write.
    assign fire = (state == ARMED) && reached;

`ifdef TIMESTAMP_ALARM_PERIODIC_EN
    logic period_wr;
    assign period_wr       = bus.wr_en && (bus.wr_addr == ADDR_PERIOD);
    assign periodic_active = ctrl_periodic && (period != '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ctrl_periodic <= 1'b0;
            period        <= '0;
        end else begin
            if (ctrl_wr)   ctrl_periodic <= bus.wr_data[CTRL_PERIODIC];
            if (period_wr) period        <= bus.wr_data;
        end
    end
`else
    assign ctrl_periodic   = 1'b0;
    assign period          = '0;
    assign periodic_active = 1'b0;
`endif

    // NOTE: every register here uses non-blocking assignment so all state updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // NOTE: default assignment first keeps this process free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            ARMED:   if (fire && !periodic_active) state_nxt = FIRED;
            IDLE,
            FIRED:   state_nxt = state;
            default: state_nxt = IDLE;
        endcase
        // A CTRL write lands after the compare, so it overrides the fire transition.
        if (ctrl_wr) begin
            if (bus.wr_data[CTRL_ARM]) state_nxt = ARMED;
            else if (state == ARMED)   state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ctrl_ie  <= 1'b0;
            deadline <= '0;
            fired    <= 1'b0;
            missed   <= 1'b0;
        end else begin
            if (ctrl_wr) ctrl_ie <= bus.wr_data[CTRL_IE];

            if (deadline_wr)                 deadline <= bus.wr_data;
            else if (fire && periodic_active) deadline <= deadline + period;

            // A new fire beats a simultaneous W1C so no event is lost.
            if (fire)                                        fired <= 1'b1;
            else if (status_wr && bus.wr_data[STATUS_FIRED]) fired <= 1'b0;

            if (fire && fired)                                missed <= 1'b1;
            else if (status_wr && bus.wr_data[STATUS_MISSED]) missed <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.rd_addr)
            ADDR_CTRL: begin
                rd_mux[CTRL_ARM]      = (state == ARMED);
                rd_mux[CTRL_IE]       = ctrl_ie;
                rd_mux[CTRL_PERIODIC] = ctrl_periodic;
            end
            ADDR_DEADLINE: rd_mux = deadline;
            ADDR_PERIOD:   rd_mux = period;
            ADDR_STATUS: begin
                rd_mux[STATUS_FIRED]  = fired;
                rd_mux[STATUS_MISSED] = missed;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) bus.rd_data <= rd_mux;
        end
    end

    assign irq = fired & ctrl_ie;

endmodule

// File: tb/tb_timestamp_alarm.sv
// Directed self-checking bench for timestamp_alarm; periodic cases run when TIMESTAMP_ALARM_PERIODIC_EN is defined.
module tb_timestamp_alarm;
    import timestamp_alarm_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] ts = 32'hFFFF_FFFF;
    logic        irq;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] rv;

    timestamp_alarm_if bus ();

    timestamp_alarm dut (
        .clk       (clk),
        .resetn    (resetn),
        .timestamp (ts),
        .bus       (bus),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr;
        tick();
        bus.rd_en   = 1'b0;
        check({tag, "_valid"}, {31'b0, bus.rd_valid}, 32'd1);
        check(tag, bus.rd_data, exp);
    endtask

    task automatic ramp_to(input logic [31:0] target);
        while (ts != target) begin
            ts = ts + 1;
            tick();
        end
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;

        // Reset state
        tick(); tick();
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
        check("rst_rd_data", bus.rd_data, 32'd0);
        resetn = 1'b1;
        rd("rst_ctrl", ADDR_CTRL, 32'd0);
        rd("rst_deadline", ADDR_DEADLINE, 32'd0);
        rd("rst_status", ADDR_STATUS, 32'd0);

        // 1: one-shot fire at ts=10
        wr(ADDR_DEADLINE, 32'd10);
        wr(ADDR_CTRL, 32'd3);
        rd("t1_ctrl_armed", ADDR_CTRL, 32'd3);
        for (int t = 0; t <= 10; t++) begin
            ts = t;
            tick();
            if (t == 9)  check("t1_irq_before", {31'b0, irq}, 32'd0);
            if (t == 10) check("t1_irq_fire", {31'b0, irq}, 32'd1);
        end
        rd("t1_status", ADDR_STATUS, 32'd1);
        rd("t1_ctrl_disarmed", ADDR_CTRL, 32'd2);

        // 2: deadline across the 2^32 wrap
        wr(ADDR_STATUS, 32'd3);
        check("t2_irq_cleared", {31'b0, irq}, 32'd0);
        ts = 32'hFFFF_FFF0;
        wr(ADDR_DEADLINE, 32'd5);
        wr(ADDR_CTRL, 32'd3);
        for (int i = 0; i <= 21; i++) begin
            ts = 32'hFFFF_FFF0 + i;
            tick();
            check($sformatf("t2_irq_%0d", i), {31'b0, irq}, (i == 21) ? 32'd1 : 32'd0);
        end

        // 3: second fire while fired still set, with W1C of fired in the same cycle
        wr(ADDR_DEADLINE, 32'd3);
        wr(ADDR_CTRL, 32'd3);
        wr(ADDR_STATUS, 32'd1);
        rd("t3_status", ADDR_STATUS, 32'd3);
        check("t3_irq", {31'b0, irq}, 32'd1);
        rd("t3_ctrl", ADDR_CTRL, 32'd2);
        wr(ADDR_STATUS, 32'd3);
        rd("t3_status_clr", ADDR_STATUS, 32'd0);
        rd("t3_status_no_cor", ADDR_STATUS, 32'd0);

`ifdef TIMESTAMP_ALARM_PERIODIC_EN
        // 4: periodic reload 100,150,200,250
        ts = 32'd0;
        wr(ADDR_DEADLINE, 32'd100);
        wr(ADDR_PERIOD, 32'd50);
        wr(ADDR_CTRL, 32'd7);
        for (int k = 0; k < 4; k++) begin
            ramp_to(32'd99 + 32'(50 * k));
            check($sformatf("t4_irq_pre_%0d", k), {31'b0, irq}, 32'd0);
            ramp_to(32'd100 + 32'(50 * k));
            check($sformatf("t4_irq_fire_%0d", k), {31'b0, irq}, 32'd1);
            wr(ADDR_STATUS, 32'd1);
        end
        rd("t4_deadline", ADDR_DEADLINE, 32'd300);
        rd("t4_status", ADDR_STATUS, 32'd0);
        rd("t4_ctrl", ADDR_CTRL, 32'd7);
        wr(ADDR_CTRL, 32'd0);
        wr(ADDR_PERIOD, 32'd0);
`else
        // 4: periodic feature absent
        wr(ADDR_PERIOD, 32'd50);
        rd("t4_period_ro", ADDR_PERIOD, 32'd0);
        wr(ADDR_DEADLINE, 32'd1000);
        wr(ADDR_CTRL, 32'd7);
        rd("t4_ctrl_no_periodic", ADDR_CTRL, 32'd3);
        wr(ADDR_CTRL, 32'd0);
        rd("t4_ctrl_off", ADDR_CTRL, 32'd0);
`endif

        // 5: disarm before the deadline, then fire with ie=0, then fire + disarm together
        ts = 32'd0;
        wr(ADDR_STATUS, 32'd3);
        wr(ADDR_DEADLINE, 32'd1000);
        wr(ADDR_CTRL, 32'd3);
        ramp_to(32'd500);
        wr(ADDR_CTRL, 32'd2);
        ramp_to(32'd2000);
        check("t5_irq_disarmed", {31'b0, irq}, 32'd0);
        rd("t5_status_disarmed", ADDR_STATUS, 32'd0);
        rd("t5_ctrl_disarmed", ADDR_CTRL, 32'd2);

        wr(ADDR_DEADLINE, 32'd2100);
        wr(ADDR_CTRL, 32'd1);
        ramp_to(32'd2100);
        check("t5_irq_ie0", {31'b0, irq}, 32'd0);
        rd("t5_status_ie0", ADDR_STATUS, 32'd1);
        rd("t5_ctrl_ie0", ADDR_CTRL, 32'd0);

        wr(ADDR_STATUS, 32'd3);
        wr(ADDR_DEADLINE, 32'd2200);
        wr(ADDR_CTRL, 32'd3);
        ramp_to(32'd2199);
        ts = 32'd2200;
        wr(ADDR_CTRL, 32'd0);
        rd("t5_status_fire_disarm", ADDR_STATUS, 32'd1);
        rd("t5_ctrl_fire_disarm", ADDR_CTRL, 32'd0);

        // 6: reset while fired with irq asserted
        wr(ADDR_STATUS, 32'd3);
        wr(ADDR_DEADLINE, 32'd2300);
        wr(ADDR_CTRL, 32'd3);
        ramp_to(32'd2300);
        check("t6_irq_before_rst", {31'b0, irq}, 32'd1);
        resetn = 1'b0;
        ts     = 32'hFFFF_FFFF;
        tick();
        check("t6_irq_rst", {31'b0, irq}, 32'd0);
        check("t6_rd_valid_rst", {31'b0, bus.rd_valid}, 32'd0);
        check("t6_rd_data_rst", bus.rd_data, 32'd0);
        resetn = 1'b1;
        rd("t6_ctrl", ADDR_CTRL, 32'd0);
        rd("t6_deadline", ADDR_DEADLINE, 32'd0);
        rd("t6_period", ADDR_PERIOD, 32'd0);
        rd("t6_status", ADDR_STATUS, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
